// File: rtl/vertex_transform_unit_if.sv
// Vertex transform unit bus bundle.
// Groups the matrix-load port, the input vertex handshake and the output
// vertex handshake. The master modport belongs to the vertex source /
// rasteriser side. The slave modport belongs to the transform unit.
//   matrix:  i_mat_we, i_mat_addr, i_mat_wdata, i_mat_commit
//   vertex:  i_vtx_valid / o_vtx_ready, i_x, i_y, i_z, i_u, i_v
//   output:  o_valid / i_ready, o_x, o_y, o_z, o_u, o_v
//   status:  o_cull_count, o_busy
interface vertex_transform_unit_if #(
    parameter int DATA_W = 32,
    parameter int Z_BITS = 8
);
    logic              i_mat_we;
    logic [3:0]        i_mat_addr;
    logic [DATA_W-1:0] i_mat_wdata;
    logic              i_mat_commit;

    logic              i_vtx_valid;
    logic              o_vtx_ready;
    logic [DATA_W-1:0] i_x;
    logic [DATA_W-1:0] i_y;
    logic [DATA_W-1:0] i_z;
    logic [DATA_W-1:0] i_u;
    logic [DATA_W-1:0] i_v;

    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_x;
    logic [DATA_W-1:0] o_y;
    logic [Z_BITS-1:0] o_z;
    logic [DATA_W-1:0] o_u;
    logic [DATA_W-1:0] o_v;

    logic [15:0]       o_cull_count;
    logic              o_busy;

    modport master (
        output i_mat_we, i_mat_addr, i_mat_wdata, i_mat_commit,
        output i_vtx_valid, i_x, i_y, i_z, i_u, i_v, i_ready,
        input  o_vtx_ready, o_valid, o_x, o_y, o_z, o_u, o_v,
        input  o_cull_count, o_busy
    );

    modport slave (
        input  i_mat_we, i_mat_addr, i_mat_wdata, i_mat_commit,
        input  i_vtx_valid, i_x, i_y, i_z, i_u, i_v, i_ready,
        output o_vtx_ready, o_valid, o_x, o_y, o_z, o_u, o_v,
        output o_cull_count, o_busy
    );
endinterface

// File: rtl/vertex_transform_unit.sv
// Streaming vertex transform stage.
// Multiplies object-space vertices by a double-buffered 4x4 MVP matrix. It
// culls vertices whose clip W is below the near plane. It performs the
// perspective divide on one shared serial restoring divider, then maps the
// result to viewport coordinates. Only one vertex is in flight at a time.
// Ports:
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset
//   bus     - vertex_transform_unit_if.slave:
//             matrix load/commit, input vertex handshake, output vertex
//             handshake, cull counter and busy flag
module vertex_transform_unit #(
    parameter int                 DATA_W    = 32,
    parameter int                 FRAC_BITS = 16,
    parameter int                 SCREEN_W  = 320,
    parameter int                 SCREEN_H  = 240,
    parameter int                 Z_BITS    = 8,
    parameter logic signed [DATA_W-1:0] NEAR_W = 32'h00001999
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    vertex_transform_unit_if.slave bus
);
    localparam int DIV_CYC = DATA_W + FRAC_BITS;
    localparam int CNT_W   = $clog2(DIV_CYC);

    typedef logic signed [DATA_W-1:0] word_t;

    localparam word_t ONE      = word_t'(1) << FRAC_BITS;
    localparam word_t SX_SCALE = word_t'(SCREEN_W / 2) << FRAC_BITS;
    localparam word_t SY_SCALE = word_t'(SCREEN_H / 2) << FRAC_BITS;
    localparam word_t SX_MAX   = (word_t'(SCREEN_W) << FRAC_BITS) - word_t'(1);
    localparam word_t SY_MAX   = (word_t'(SCREEN_H) << FRAC_BITS) - word_t'(1);
    localparam word_t SZ_SCALE = word_t'((1 << Z_BITS) - 1) << (FRAC_BITS - 1);
    localparam word_t Z_MAX    = word_t'((1 << Z_BITS) - 1);
    localparam logic [DIV_CYC-1:0] Q_MAX = {{(FRAC_BITS + 1){1'b0}}, {(DATA_W - 1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFORM,
        S_CHECK,
        S_DIV,
        S_VIEWPORT,
        S_OUT
    } state_t;

    state_t state, state_nx;

    word_t shadow [16];
    word_t active [16];
    logic  commit_pending;

    word_t             vx, vy, vz;
    logic [DATA_W-1:0] vu, vv;
    word_t             clip_x, clip_y, clip_z, clip_w;
    word_t             ndc_x, ndc_y, ndc_z;

    // The divider packs the dividend and the quotient into one shift
    // register. Dividend bits leave at the top and quotient bits enter at the
    // bottom. After DIV_CYC shifts, the register holds only the quotient.
    logic [DIV_CYC-1:0] div_dq;
    logic [DATA_W-1:0]  div_rem;
    logic [CNT_W-1:0]   div_cnt;
    logic [1:0]         div_sel;
    logic               div_neg;

    word_t             out_x, out_y;
    logic [Z_BITS-1:0] out_z;
    logic [DATA_W-1:0] out_u, out_v;
    logic [15:0]       cull_count;

    logic               accept;
    logic               cull;
    logic               div_last;
    logic               load_div;
    word_t              load_num;
    logic [DATA_W:0]    rem_sh;
    logic               rem_fits;
    logic [DATA_W-1:0]  rem_nx;
    logic [DIV_CYC-1:0] dq_nx;
    word_t              quo_mag;
    word_t              div_result;

    function automatic word_t mul(input word_t a, input word_t b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        p = p >>> FRAC_BITS;
        return p[DATA_W-1:0];
    endfunction

    function automatic word_t clamp(input word_t val, input word_t hi);
        if (val < word_t'(0)) return '0;
        if (val > hi)         return hi;
        return val;
    endfunction

    function automatic word_t dot4(input word_t m0, input word_t m1, input word_t m2,
                                   input word_t m3, input word_t a, input word_t b,
                                   input word_t c);
        return mul(m0, a) + mul(m1, b) + mul(m2, c) + mul(m3, ONE);
    endfunction

    function automatic logic [DATA_W-1:0] abs_word(input word_t val);
        return val[DATA_W-1] ? -val : val;
    endfunction

    function automatic logic [Z_BITS-1:0] depth(input word_t ndc);
        word_t s;
        s = mul(ndc + ONE, SZ_SCALE) >>> FRAC_BITS;
        s = clamp(s, Z_MAX);
        return s[Z_BITS-1:0];
    endfunction

    assign cull     = clip_w < NEAR_W;
    assign div_last = div_cnt == CNT_W'(DIV_CYC - 1);

    always_comb begin
        rem_sh     = {div_rem, div_dq[DIV_CYC-1]};
        rem_fits   = rem_sh >= {1'b0, clip_w};
        rem_nx     = rem_fits ? DATA_W'(rem_sh - {1'b0, clip_w}) : rem_sh[DATA_W-1:0];
        dq_nx      = {div_dq[DIV_CYC-2:0], rem_fits};
        quo_mag    = (dq_nx > Q_MAX) ? word_t'(Q_MAX[DATA_W-1:0]) : word_t'(dq_nx[DATA_W-1:0]);
        div_result = div_neg ? -quo_mag : quo_mag;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load_div = 1'b0;
        load_num = clip_x;
        case (state)
            S_IDLE: begin
                if (!commit_pending && bus.i_vtx_valid) begin
                    accept   = 1'b1;
                    state_nx = S_XFORM;
                end
            end
            S_XFORM: state_nx = S_CHECK;
            S_CHECK: begin
                if (cull) begin
                    state_nx = S_IDLE;
                end else begin
                    load_div = 1'b1;
                    state_nx = S_DIV;
                end
            end
            S_DIV: begin
                if (div_last) begin
                    if (div_sel == 2'd2) begin
                        state_nx = S_VIEWPORT;
                    end else begin
                        load_div = 1'b1;
                        load_num = (div_sel == 2'd0) ? clip_y : clip_z;
                    end
                end
            end
            S_VIEWPORT: state_nx = S_OUT;
            S_OUT: begin
                if (bus.i_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The shadow bank accepts writes at any time. The copy to the active bank
    // waits for S_IDLE, so a vertex in flight keeps its matrix. A commit pulse
    // in the copy cycle re-arms pending. This makes a write issued with that
    // pulse reach the active bank on the next copy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                shadow[i[3:0]] <= (i % 5 == 0) ? ONE : '0;
                active[i[3:0]] <= (i % 5 == 0) ? ONE : '0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (bus.i_mat_we) shadow[bus.i_mat_addr] <= word_t'(bus.i_mat_wdata);
            if (state == S_IDLE && commit_pending) begin
                for (int unsigned i = 0; i < 16; i++) active[i[3:0]] <= shadow[i[3:0]];
            end
            commit_pending <= bus.i_mat_commit | (commit_pending & (state != S_IDLE));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vx         <= '0;
            vy         <= '0;
            vz         <= '0;
            vu         <= '0;
            vv         <= '0;
            clip_x     <= '0;
            clip_y     <= '0;
            clip_z     <= '0;
            clip_w     <= '0;
            ndc_x      <= '0;
            ndc_y      <= '0;
            ndc_z      <= '0;
            div_dq     <= '0;
            div_rem    <= '0;
            div_cnt    <= '0;
            div_sel    <= '0;
            div_neg    <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_z      <= '0;
            out_u      <= '0;
            out_v      <= '0;
            cull_count <= '0;
        end else begin
            if (accept) begin
                vx <= word_t'(bus.i_x);
                vy <= word_t'(bus.i_y);
                vz <= word_t'(bus.i_z);
                vu <= bus.i_u;
                vv <= bus.i_v;
            end
            if (state == S_XFORM) begin
                clip_x <= dot4(active[0],  active[1],  active[2],  active[3],  vx, vy, vz);
                clip_y <= dot4(active[4],  active[5],  active[6],  active[7],  vx, vy, vz);
                clip_z <= dot4(active[8],  active[9],  active[10], active[11], vx, vy, vz);
                clip_w <= dot4(active[12], active[13], active[14], active[15], vx, vy, vz);
            end
            if (state == S_CHECK && cull && cull_count != '1) cull_count <= cull_count + 1'b1;

            // The reload for the next component shares the edge that retires
            // the current quotient. div_result still sees the old div_neg.
            if (load_div) begin
                div_dq  <= {abs_word(load_num), {FRAC_BITS{1'b0}}};
                div_rem <= '0;
                div_cnt <= '0;
                div_neg <= load_num[DATA_W-1];
            end else if (state == S_DIV) begin
                div_dq  <= dq_nx;
                div_rem <= rem_nx;
                div_cnt <= div_cnt + 1'b1;
            end
            if (state == S_CHECK) begin
                div_sel <= '0;
            end else if (state == S_DIV && div_last) begin
                div_sel <= div_sel + 1'b1;
                case (div_sel)
                    2'd0:    ndc_x <= div_result;
                    2'd1:    ndc_y <= div_result;
                    default: ndc_z <= div_result;
                endcase
            end

            if (state == S_VIEWPORT) begin
                out_x <= clamp(mul(ndc_x + ONE, SX_SCALE), SX_MAX);
                out_y <= clamp(mul(ndc_y + ONE, SY_SCALE), SY_MAX);
                out_z <= depth(ndc_z);
                out_u <= vu;
                out_v <= vv;
            end
        end
    end

    assign bus.o_vtx_ready  = (state == S_IDLE) && !commit_pending;
    assign bus.o_valid      = state == S_OUT;
    assign bus.o_busy       = state != S_IDLE;
    assign bus.o_x          = out_x;
    assign bus.o_y          = out_y;
    assign bus.o_z          = out_z;
    assign bus.o_u          = out_u;
    assign bus.o_v          = out_v;
    assign bus.o_cull_count = cull_count;
endmodule
